// File: rtl/ysyx_22040365_pkg.sv
// Shared definitions for the write-back stage: default widths, load funct3
// encodings and the write-back FSM state type.
package ysyx_22040365_pkg;

  localparam int DEF_XLEN   = 64;
  localparam int DEF_RIDX_W = 5;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/ysyx_22040365_load_ext.sv
// Load data extraction: shifts the addressed bytes down from the aligned
// doubleword and sign/zero-extends them according to funct3.
module ysyx_22040365_load_ext
  import ysyx_22040365_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [2:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  logic [XLEN-1:0] shifted;

  // Logical shift: bytes pushed past the top of the doubleword read as zero.
  assign shifted = mem_rdata >> {off, 3'b000};

  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (funct3)
      LB:      data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LH:      data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LW:      data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LD:      data = shifted;
      LBU:     data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LHU:     data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LWU:     data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_22040365_wb_stage.sv
// Write-back stage: accepts one retiring instruction, waits for load data when
// needed, then issues a single-cycle register-file write and counts retirement.
module ysyx_22040365_wb_stage
  import ysyx_22040365_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int RIDX_W = DEF_RIDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic              in_wen,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic              in_is_load,
  input  logic [2:0]        in_ld_funct3,
  input  logic [2:0]        in_ld_off,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rf_wen,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              fwd_valid,
  output logic [RIDX_W-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic              load_err,
  output logic [63:0]       instret
);

  wb_state_t         state_reg, state_next;
  logic [RIDX_W-1:0] rd_reg;
  logic              wen_reg;
  logic [2:0]        funct3_reg;
  logic [2:0]        off_reg;
  logic [XLEN-1:0]   data_reg;
  logic              rf_wen_reg;
  logic [RIDX_W-1:0] rf_waddr_reg;
  logic [XLEN-1:0]   rf_wdata_reg;
  logic              load_err_reg;
  logic [63:0]       instret_reg;

  logic              accept;
  logic              enter_write;
  logic [XLEN-1:0]   data_next;
  logic              err_next;
  logic [RIDX_W-1:0] rd_src;
  logic              wen_src;
  logic [XLEN-1:0]   ext_data;
  logic              ext_illegal;

  ysyx_22040365_load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .mem_rdata(mem_rdata),
    .off      (off_reg),
    .funct3   (funct3_reg),
    .data     (ext_data),
    .illegal  (ext_illegal)
  );

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    enter_write = 1'b0;
    data_next   = data_reg;
    err_next    = 1'b0;
    case (state_reg)
      WB_IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (in_is_load) begin
            state_next = WB_WAIT_MEM;
          end else begin
            state_next  = WB_WRITE;
            enter_write = 1'b1;
            data_next   = in_alu_result;
          end
        end
      end
      WB_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_next  = WB_WRITE;
          enter_write = 1'b1;
          data_next   = ext_data;
          err_next    = ext_illegal;
        end
      end
      WB_WRITE: state_next = WB_IDLE;
      default:  state_next = WB_IDLE;
    endcase
  end

  // A non-load enters WRITE on the accepting edge, so its rd/wen come straight
  // from the inputs rather than from the latches being loaded on that edge.
  assign rd_src  = accept ? in_rd  : rd_reg;
  assign wen_src = accept ? in_wen : wen_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= WB_IDLE;
      rd_reg       <= '0;
      wen_reg      <= 1'b0;
      funct3_reg   <= 3'b000;
      off_reg      <= 3'b000;
      data_reg     <= '0;
      rf_wen_reg   <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      load_err_reg <= 1'b0;
      instret_reg  <= 64'd0;
    end else begin
      state_reg    <= state_next;
      rf_wen_reg   <= enter_write && wen_src && (rd_src != '0);
      load_err_reg <= err_next;
      if (accept) begin
        rd_reg     <= in_rd;
        wen_reg    <= in_wen;
        funct3_reg <= in_ld_funct3;
        off_reg    <= in_ld_off;
      end
      if (enter_write) begin
        data_reg     <= data_next;
        rf_waddr_reg <= rd_src;
        rf_wdata_reg <= data_next;
        instret_reg  <= instret_reg + 64'd1;
      end
    end
  end

  assign in_ready  = (state_reg == WB_IDLE);
  assign rf_wen    = rf_wen_reg;
  assign rf_waddr  = rf_waddr_reg;
  assign rf_wdata  = rf_wdata_reg;
  assign load_err  = load_err_reg;
  assign instret   = instret_reg;
  assign fwd_valid = ((state_reg == WB_WAIT_MEM) || (state_reg == WB_WRITE))
                     && wen_reg && (rd_reg != '0);
  assign fwd_rd    = rd_reg;
  assign fwd_data  = data_reg;

endmodule

// File: tb/tb_ysyx_22040365_wb_stage.sv
// Self-checking bench for the write-back stage: directed cases followed by
// randomized transactions checked against a byte-level load model.
module tb_ysyx_22040365_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic [63:0] in_alu_result;
  logic        in_is_load;
  logic [2:0]  in_ld_funct3;
  logic [2:0]  in_ld_off;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic        load_err;
  logic [63:0] instret;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_instret = 64'd0;
  logic [63:0] last_waddr = 64'd0;
  logic [63:0] last_wdata = 64'd0;

  logic [4:0]  r_rd;
  logic        r_wen;
  logic [63:0] r_alu;
  logic        r_ld;
  logic [2:0]  r_f3;
  logic [2:0]  r_off;
  int          r_dly;
  logic [63:0] r_mem;
  logic [63:0] r_exp;
  logic        r_ill;

  always #5 clk = ~clk;

  ysyx_22040365_wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_wen       (in_wen),
    .in_alu_result(in_alu_result),
    .in_is_load   (in_is_load),
    .in_ld_funct3 (in_ld_funct3),
    .in_ld_off    (in_ld_off),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .load_err     (load_err),
    .instret      (instret)
  );

  // Reference: funct3[1:0] gives log2 of the access size, funct3[2] means
  // zero-extend, and 7 is illegal.
  function automatic logic [63:0] ref_load(input logic [63:0] d, input int off,
                                           input int f3, output logic ill);
    int          nbytes;
    logic [63:0] mask;
    logic [63:0] v;
    ill = 1'b0;
    if (f3 == 7) begin
      ill = 1'b1;
      return 64'd0;
    end
    nbytes = 1 << (f3 % 4);
    mask   = (nbytes == 8) ? ~64'd0 : ((64'd1 << (nbytes * 8)) - 64'd1);
    v      = (d >> (off * 8)) & mask;
    if (f3 < 4 && nbytes < 8 && (((v >> (nbytes * 8 - 1)) & 64'd1) == 64'd1))
      v = v | ~mask;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    in_rd         = 5'($urandom);
    in_wen        = 1'($urandom);
    in_alu_result = {$urandom, $urandom};
    in_is_load    = 1'($urandom);
    in_ld_funct3  = 3'($urandom);
    in_ld_off     = 3'($urandom);
  endtask

  task automatic txn(input logic [4:0] rd, input logic wen, input logic [63:0] alu,
                     input logic is_load, input logic [2:0] f3, input logic [2:0] off,
                     input int delay, input logic [63:0] rdata,
                     input logic [63:0] exp_data, input logic exp_err);
    logic fv;
    fv = wen && (rd != 5'd0);
    $display("txn rd=%0d wen=%0b load=%0b f3=%0d off=%0d delay=%0d rdata=0x%016h exp=0x%016h err=%0b",
             rd, wen, is_load, f3, off, delay, rdata, exp_data, exp_err);
    in_rd = rd; in_wen = wen; in_alu_result = alu; in_is_load = is_load;
    in_ld_funct3 = f3; in_ld_off = off; in_valid = 1'b1;
    chk("accept_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    scramble_inputs();
    if (is_load) begin
      for (int i = 0; i < delay; i++) begin
        chk("wait_ready", {63'd0, in_ready}, 64'd0);
        chk("wait_fwd_valid", {63'd0, fwd_valid}, {63'd0, fv});
        chk("wait_fwd_rd", {59'd0, fwd_rd}, {59'd0, rd});
        chk("wait_rf_wen", {63'd0, rf_wen}, 64'd0);
        tick();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
    end
    exp_instret = exp_instret + 64'd1;
    chk("write_rf_wen", {63'd0, rf_wen}, {63'd0, fv});
    chk("write_waddr", {59'd0, rf_waddr}, {59'd0, rd});
    chk("write_wdata", rf_wdata, exp_data);
    chk("write_load_err", {63'd0, load_err}, {63'd0, exp_err});
    chk("write_instret", instret, exp_instret);
    chk("write_ready", {63'd0, in_ready}, 64'd0);
    chk("write_fwd_valid", {63'd0, fwd_valid}, {63'd0, fv});
    if (fv) chk("write_fwd_data", fwd_data, exp_data);
    last_waddr = {59'd0, rd};
    last_wdata = exp_data;
    tick();
    chk("idle_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("idle_load_err", {63'd0, load_err}, 64'd0);
    chk("idle_ready", {63'd0, in_ready}, 64'd1);
    chk("idle_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("hold_waddr", {59'd0, rf_waddr}, last_waddr);
    chk("hold_wdata", rf_wdata, last_wdata);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    in_rd = 5'd0; in_wen = 1'b0; in_alu_result = 64'd0; in_is_load = 1'b0;
    in_ld_funct3 = 3'd0; in_ld_off = 3'd0;
    tick();
    tick();
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    chk("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("rst_fwd_rd", {59'd0, fwd_rd}, 64'd0);
    chk("rst_fwd_data", fwd_data, 64'd0);
    chk("rst_load_err", {63'd0, load_err}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    rst = 1'b0;
    tick();

    // Reset while a load waits on memory, with a response arriving on the same edge.
    $display("txn reset during WAIT_MEM");
    in_rd = 5'd7; in_wen = 1'b1; in_is_load = 1'b1; in_ld_funct3 = 3'd3; in_ld_off = 3'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("midrst_wait_fwd", {63'd0, fwd_valid}, 64'd1);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    rst = 1'b0; mem_rvalid = 1'b0;
    chk("midrst_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("midrst_instret", instret, 64'd0);
    chk("midrst_load_err", {63'd0, load_err}, 64'd0);
    chk("midrst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    tick();
    chk("midrst_after_wen", {63'd0, rf_wen}, 64'd0);
    chk("midrst_after_instret", instret, 64'd0);

    txn(5'd5, 1'b1, 64'h1234, 1'b0, 3'd0, 3'd0, 0, 64'd0, 64'h1234, 1'b0);
    txn(5'd3, 1'b1, 64'd0, 1'b1, 3'd0, 3'd3, 4, 64'h0000_0000_8000_0000,
        64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    txn(5'd4, 1'b1, 64'd0, 1'b1, 3'd4, 3'd3, 1, 64'h0000_0000_8000_0000, 64'h80, 1'b0);
    txn(5'd6, 1'b1, 64'd0, 1'b1, 3'd6, 3'd4, 0, 64'hDEAD_BEEF_0000_0000,
        64'h0000_0000_DEAD_BEEF, 1'b0);
    txn(5'd8, 1'b1, 64'd0, 1'b1, 3'd2, 3'd4, 2, 64'hDEAD_BEEF_0000_0000,
        64'hFFFF_FFFF_DEAD_BEEF, 1'b0);
    txn(5'd10, 1'b1, 64'd0, 1'b1, 3'd3, 3'd5, 1, 64'h1122_3344_5566_7788,
        64'h0000_0000_0011_2233, 1'b0);
    txn(5'd11, 1'b1, 64'd0, 1'b1, 3'd1, 3'd6, 0, 64'h8001_0000_0000_0000,
        64'hFFFF_FFFF_FFFF_8001, 1'b0);
    txn(5'd0, 1'b1, 64'h55, 1'b0, 3'd0, 3'd0, 0, 64'd0, 64'h55, 1'b0);
    txn(5'd12, 1'b0, 64'h77, 1'b0, 3'd0, 3'd0, 0, 64'd0, 64'h77, 1'b0);
    txn(5'd9, 1'b1, 64'd0, 1'b1, 3'd7, 3'd2, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);

    // Stray memory response while idle must not cause a write.
    $display("txn stray mem_rvalid in IDLE");
    mem_rvalid = 1'b1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    mem_rvalid = 1'b0;
    chk("stray_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("stray_ready", {63'd0, in_ready}, 64'd1);
    chk("stray_instret", instret, exp_instret);

    for (int n = 0; n < 60; n++) begin
      r_rd  = 5'($urandom);
      r_wen = 1'($urandom);
      r_alu = {$urandom, $urandom};
      r_ld  = 1'($urandom);
      r_f3  = 3'($urandom);
      r_off = 3'($urandom);
      r_dly = int'($urandom_range(4, 0));
      r_mem = {$urandom, $urandom};
      if (r_ld) begin
        r_exp = ref_load(r_mem, int'(r_off), int'(r_f3), r_ill);
      end else begin
        r_exp = r_alu;
        r_ill = 1'b0;
      end
      txn(r_rd, r_wen, r_alu, r_ld, r_f3, r_off, r_dly, r_mem, r_exp, r_ill);
      if ($urandom_range(1, 0) == 1) begin
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("rand_stray_rf_wen", {63'd0, rf_wen}, 64'd0);
        chk("rand_stray_ready", {63'd0, in_ready}, 64'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22040365_wb_stage.md
Name: ysyx_22040365_wb_stage

Overview:
- Write-back stage directly upstream of the integer register file; sole driver of its write port.
- Accepts one retiring instruction at a time from EXU/LSU over a valid/ready handshake.
- For loads, waits for the memory read response, then aligns and sign/zero-extends it.
- Emits a single-cycle register write, a forwarding view of the pending write, and a 64-bit retired-instruction counter.

Parameters:
- XLEN, 64, datapath and register width.
- RIDX_W, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage can accept; high only in IDLE.
- in_rd  input  RIDX_W  destination register index.
- in_wen  input  1  instruction writes rd.
- in_alu_result  input  XLEN  result for non-load instructions.
- in_is_load  input  1  instruction is a load.
- in_ld_funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 illegal.
- in_ld_off  input  3  byte offset of the load address inside the aligned doubleword.
- mem_rvalid  input  1  memory read data valid.
- mem_rdata  input  XLEN  aligned doubleword from memory.
- rf_wen  output  1  register-file write enable, one-cycle pulse.
- rf_waddr  output  RIDX_W  register-file write index.
- rf_wdata  output  XLEN  register-file write data.
- fwd_valid  output  1  a write to fwd_rd is pending or occurring.
- fwd_rd  output  RIDX_W  pending destination index.
- fwd_data  output  XLEN  pending write data; meaningful only in WRITE.
- load_err  output  1  one-cycle pulse on an illegal load funct3.
- instret  output  64  count of retired instructions.

Behaviour:
- FSM states: IDLE, WAIT_MEM, WRITE. Reset enters IDLE.
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, fwd_valid=0, fwd_rd=0, fwd_data=0, load_err=0, instret=0, in_ready=1.
- IDLE:
  - Accept on in_valid && in_ready; latch rd, wen, alu_result, is_load, funct3, off.
  - Non-load: go to WRITE and capture data = in_alu_result.
  - Load: go to WAIT_MEM.
- WAIT_MEM:
  - in_ready=0. mem_rvalid is ignored in every state except WAIT_MEM.
  - On mem_rvalid, compute the extended value from mem_rdata, capture it, go to WRITE.
  - Wait time is unbounded.
- Load extraction:
  - shifted = mem_rdata >> (off*8), logical shift; bytes beyond bit 63 read as 0.
  - Then take 8, 16, 32 or 64 bits and sign- or zero-extend by funct3.
  - funct3=111: data=0 and load_err pulses in the WRITE cycle.
- WRITE (exactly one cycle, then IDLE):
  - rf_wen = latched wen && rd!=0. x0 writes are always suppressed.
  - rf_waddr=rd, rf_wdata=data.
  - instret increments by 1 regardless of wen or rd, and wraps modulo 2^64.
- Outputs outside WRITE: rf_wen=0; rf_waddr and rf_wdata hold their last values.
- Forwarding:
  - fwd_valid = (WAIT_MEM or WRITE) && wen && rd!=0.
  - fwd_rd = latched rd.
  - fwd_data = captured data.
- Throughput:
  - Non-load: accept at cycle N, write at N+1, next accept at N+2.
  - Load: write one cycle after mem_rvalid.
- rst mid-operation: the in-flight instruction is discarded with no write, no instret increment and no load_err; return to IDLE next cycle.

Decomposition:
- Shared package ysyx_22040365_pkg holds:
  - Load funct3 constants: LB, LH, LW, LD, LBU, LHU, LWU.
  - WB FSM state encoding.
  - XLEN and RIDX_W defaults.
- Sub-module ysyx_22040365_load_ext is purely combinational: in mem_rdata, off, funct3; out data, illegal.

Test Plan:
- Reset, then in_valid with rd=5, in_alu_result=0x1234, in_is_load=0 -> in_ready drops, next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, instret=1.
- Load lb at off=3, mem_rvalid 4 cycles later with mem_rdata=0x0000_0000_8000_0000 (byte 3 = 0x80) -> rf_wdata=0xFFFF_FFFF_FFFF_FF80; fwd_valid=1 throughout WAIT_MEM; in_ready=0 until the cycle after the write.
- Same data with lbu -> 0x80; lwu at off=4 with mem_rdata=0xDEAD_BEEF_0000_0000 -> 0x0000_0000_DEAD_BEEF; lw -> 0xFFFF_FFFF_DEAD_BEEF.
- rd=0 with in_wen=1 -> rf_wen stays 0, fwd_valid=0, instret still increments.
- funct3=111 load -> load_err one-cycle pulse, rf_wdata=0; mem_rvalid pulsed while in IDLE -> ignored.
- rst asserted during WAIT_MEM -> no rf_wen pulse, instret unchanged at 0 after reset, in_ready=1 the cycle after rst.
